// File: rtl/seq_mult_2bit_digit.sv
// Iterative unsigned WIDTH x WIDTH multiplier built around an external combinational
// 2x2 digit multiplier; one digit pair is issued and accumulated per clock.
module seq_mult_2bit_digit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [1:0]           mul_x,
  output logic [1:0]           mul_y,
  input  logic [3:0]           mul_p,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, product_q, product_d;
  logic [IdxW-1:0] i_q, i_d, j_q, j_d;
  logic [PW-1:0]   p_ext, acc_sum;
  int unsigned     shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;
    mul_x     = 2'b00;
    mul_y     = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    p_ext     = '0;
    p_ext[3:0] = mul_p;
    // Partial product of digits i and j carries weight 4^(i+j).
    shamt     = 2 * (32'(i_q) + 32'(j_q));
    acc_sum   = acc_q + (p_ext << shamt);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        busy  = 1'b1;
        mul_x = a_q[2*i_q +: 2];
        mul_y = b_q[2*j_q +: 2];
        acc_d = acc_sum;
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            product_d = acc_sum;
            state_d   = StDone;
          end else begin
            i_d = i_q + IdxW'(1);
          end
        end else begin
          j_d = j_q + IdxW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign product = product_q;

endmodule
